snail_frame_tx: RTL and testbench



---
 rtl/snail_frame_tx_pkg.sv | 7 +
 rtl/snail_frame_tx_tracker.sv | 14 +
 rtl/snail_frame_tx.sv | 98 +++++++++
 tb/tb_snail_frame_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/snail_frame_tx_pkg.sv
// snail_frame_tx_pkg: encodings and constants shared by the snail detector and its frame transmitter
package snail_frame_tx_pkg;
    typedef enum logic [1:0] {S0, S1, S2, S3} trk_state_t;
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} tx_state_t;
    localparam logic [3:0] PREAMBLE_BITS = 4'b1101;
    localparam int GAP_LEN = 2;
endpackage

// File: rtl/snail_frame_tx_tracker.sv
// snail_pattern_tracker: next-state function and match flag of the Mealy 1101 detector
module snail_pattern_tracker
    import snail_frame_tx_pkg::*;
(
    input  trk_state_t i_state,
    input  logic       i_bit,
    output trk_state_t o_next,
    output logic       o_match
);
    always_comb begin
        o_next  = i_bit ? ((i_state == S0 || i_state == S3) ? S1 : S2) : (i_state == S2 ? S3 : S0);
        o_match = i_bit && i_state == S3;
    end
endmodule

// File: rtl/snail_frame_tx.sv
// snail_frame_tx: sends preamble 1101, a zero-stuffed MSB-first payload and an idle gap on one serial line
module snail_frame_tx
    import snail_frame_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             number,
    output logic             busy,
    output logic             stuffed
);
    localparam int CW = $clog2(WIDTH + 1);

    tx_state_t        r_state, w_next;
    trk_state_t       r_trk, w_trk_next;
    logic [WIDTH-1:0] r_shift, w_shift;
    logic [CW-1:0]    r_cnt, w_cnt, w_base;
    logic             r_gap, w_gap, r_number, r_stuffed, r_busy;
    logic             w_bit, w_stuff, w_emit, w_match;

    // r_state and r_cnt describe the bit currently on number; this block picks the next one
    always_comb begin
        w_next  = r_state;
        w_shift = r_shift;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
        w_bit   = 1'b0;
        w_emit  = 1'b0;
        case (r_state)
            IDLE: if (data_valid) begin
                w_next  = PREAMBLE;
                w_bit   = PREAMBLE_BITS[3];
                w_cnt   = '0;
                w_shift = data_in;
            end
            PREAMBLE: if (r_cnt == CW'(3)) begin
                w_next = PAYLOAD;
                w_emit = 1'b1;
            end else begin
                w_bit = PREAMBLE_BITS[2'd2 - r_cnt[1:0]];
                w_cnt = r_cnt + CW'(1);
            end
            PAYLOAD: if (r_cnt == CW'(WIDTH)) w_next = GAP; else w_emit = 1'b1;
            GAP: begin
                w_gap = r_gap + 1'b1;
                if (r_gap == 1'(GAP_LEN - 1)) w_next = IDLE;
            end
        endcase
        w_base  = (r_state == PAYLOAD) ? r_cnt : '0;
        w_stuff = w_emit && r_trk == S3;
        if (w_emit) begin
            w_bit   = !w_stuff && r_shift[WIDTH-1];
            w_shift = w_stuff ? r_shift : r_shift << 1;
            w_cnt   = w_base + CW'(!w_stuff);
        end
    end

    snail_pattern_tracker u_trk (
        .i_state(r_trk),
        .i_bit  (w_bit),
        .o_next (w_trk_next),
        .o_match(w_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= GAP;
            r_gap     <= 1'b0;
            r_cnt     <= '0;
            r_trk     <= S0;
            r_number  <= 1'b0;
            r_stuffed <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_gap     <= w_gap;
            r_cnt     <= w_cnt;
            r_shift   <= w_shift;
            r_trk     <= w_trk_next;
            r_number  <= w_bit;
            r_stuffed <= w_stuff;
            r_busy    <= w_next != IDLE;
        end
    end

    // the only 1101 on the line must be the end of the preamble
    always_ff @(posedge clk)
        if (!reset) assert (!w_match || r_state == PREAMBLE);

    assign data_ready = r_state == IDLE;
    assign number     = r_number;
    assign busy       = r_busy;
    assign stuffed    = r_stuffed;
endmodule

// File: tb/tb_snail_frame_tx.sv
// tb_snail_frame_tx: directed and random frames checked against a 1101 detector model and de-stuffing
module tb_snail_frame_tx;
    localparam int W = 8;

    logic         clk = 1'b0, reset = 1'b1, data_valid = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_ready, number, busy, stuffed;
    int           checks = 0, fails = 0, cyc = 0, smile_cnt = 0, last_smile = -1;
    logic [1:0]   det_st = 2'd0;

    always #5 clk = ~clk;

    snail_frame_tx #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .number(number), .busy(busy), .stuffed(stuffed)
    );

    function automatic logic [1:0] det_nx(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd2 : 2'd0;
            2'd2:    return b ? 2'd2 : 2'd3;
            default: return b ? 2'd1 : 2'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) det_st <= 2'd0;
        else begin
            if (det_st == 2'd3 && number) begin
                smile_cnt  <= smile_cnt + 1;
                last_smile <= cyc;
            end
            det_st <= det_nx(det_st, number);
        end
        cyc <= cyc + 1;
    end

    task automatic test_reset;
        logic [3:0] o, e;
        reset = 1'b1;
        data_valid = 1'b0;
        repeat (3) @(negedge clk);
        o = {number, stuffed, busy, data_ready};
        checks++;
        if (o !== 4'b0010) begin fails++; $display("FAIL reset_state got %b want 0010", o); end
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            o = {number, stuffed, busy, data_ready};
            e = {1'b0, 1'b0, 1'(i < 2), 1'(i >= 2)};
            checks++;
            if (o !== e) begin fails++; $display("FAIL reset_release cycle %0d got %b want %b", i, o, e); end
        end
    endtask

    task automatic test_stuffing;
        logic [7:0]  d[2]  = '{8'hD0, 8'hB6};
        logic [16:0] en[2] = '{17'b11011100100000000, 17'b11011001100110000};
        logic [16:0] es[2] = '{17'h00200, 17'h00440};
        int          n[2]  = '{16, 17};
        logic [3:0]  o, e;
        int          a, s0;
        for (int f = 0; f < 2; f++) begin
            for (int t = 0; t < 50 && data_ready !== 1'b1; t++) @(negedge clk);
            checks++;
            if (data_ready !== 1'b1) begin fails++; $display("FAIL stuff_ready got %b want 1", data_ready); end
            data_in = d[f];
            data_valid = 1'b1;
            a = cyc;
            s0 = smile_cnt;
            @(negedge clk);
            data_in = ~d[f];
            for (int i = 1; i <= 17; i++) begin
                if (i == n[f] - 1) data_valid = 1'b0;
                o = {number, stuffed, busy, data_ready};
                e = {en[f][17-i], es[f][17-i], 1'(i < n[f]), 1'(i >= n[f])};
                checks++;
                if (o !== e) begin fails++; $display("FAIL stuff_%h A+%0d got %b want %b", d[f], i, o, e); end
                if (i < 17) @(negedge clk);
            end
            checks++;
            if (smile_cnt - s0 !== 1 || last_smile !== a + 4) begin
                fails++;
                $display("FAIL stuff_%h_smile got %0d at %0d want 1 at %0d", d[f], smile_cnt - s0, last_smile, a + 4);
            end
        end
    endtask

    task automatic test_back_to_back;
        int a1, a2, a3, s0, stf, ones1, ones2, t;
        for (int k = 0; k < 50 && data_ready !== 1'b1; k++) @(negedge clk);
        checks++;
        if (data_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b want 1", data_ready); end
        data_in = 8'hFF;
        data_valid = 1'b1;
        a1 = cyc;
        s0 = smile_cnt;
        stf = 0; ones1 = 0; ones2 = 0; t = 0;
        @(negedge clk);
        data_in = 8'h00;
        while (data_ready !== 1'b1 && t < 40) begin
            stf += int'(stuffed); ones1 += int'(number); t++;
            @(negedge clk);
        end
        a2 = cyc;
        checks++;
        if (a2 - a1 !== 15) begin fails++; $display("FAIL b2b_first_period got %0d want 15", a2 - a1); end
        @(negedge clk);
        data_valid = 1'b0;
        t = 0;
        while (data_ready !== 1'b1 && t < 40) begin
            stf += int'(stuffed); ones2 += int'(number); t++;
            @(negedge clk);
        end
        a3 = cyc;
        checks++;
        if (a3 - a2 !== 15) begin fails++; $display("FAIL b2b_second_period got %0d want 15", a3 - a2); end
        checks++;
        if (stf !== 0) begin fails++; $display("FAIL b2b_stuffed got %0d want 0", stf); end
        checks++;
        if (ones1 !== 11 || ones2 !== 3) begin fails++; $display("FAIL b2b_ones got %0d/%0d want 11/3", ones1, ones2); end
        checks++;
        if (smile_cnt - s0 !== 2) begin fails++; $display("FAIL b2b_smiles got %0d want 2", smile_cnt - s0); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] o, pre;
        int a, b, s0;
        for (int t = 0; t < 50 && data_ready !== 1'b1; t++) @(negedge clk);
        checks++;
        if (data_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %b want 1", data_ready); end
        data_in = 8'hD0;
        data_valid = 1'b1;
        a = cyc;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        s0 = smile_cnt;
        o = {number, stuffed, busy, data_ready};
        checks++;
        if (o !== 4'b0010 || cyc !== a + 8) begin fails++; $display("FAIL mid_reset_edge got %b at A+%0d want 0010 at A+8", o, cyc - a); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_early got %b want 0", data_ready); end
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_back got %b want 1", data_ready); end
        data_in = 8'h00;
        data_valid = 1'b1;
        b = cyc;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_valid = 1'b0;
            pre[3-i] = number;
        end
        checks++;
        if (pre !== 4'b1101) begin fails++; $display("FAIL mid_new_preamble got %b want 1101", pre); end
        repeat (12) @(negedge clk);
        checks++;
        if (smile_cnt - s0 !== 1 || last_smile !== b + 4) begin
            fails++;
            $display("FAIL mid_smiles got %0d at %0d want 1 at %0d", smile_cnt - s0, last_smile, b + 4);
        end
    endtask

    task automatic test_random;
        logic [7:0] d, rec;
        logic [3:0] pre;
        logic [2:0] hist;
        int a, s0, got, k, bad, i;
        for (int f = 0; f < 1000; f++) begin
            for (int t = 0; t < 50 && data_ready !== 1'b1; t++) @(negedge clk);
            checks++;
            if (data_ready !== 1'b1) begin fails++; $display("FAIL rnd_ready frame %0d got %b want 1", f, data_ready); end
            d = 8'($urandom);
            data_in = d;
            data_valid = 1'b1;
            a = cyc;
            s0 = smile_cnt;
            @(negedge clk);
            data_valid = 1'b0;
            data_in = 8'($urandom);
            pre = '0; hist = '0; rec = '0; got = 0; k = 0; bad = 0; i = 1;
            while (data_ready !== 1'b1 && i < 40) begin
                if (i <= 4) pre = {pre[2:0], number};
                else if (got < W) begin
                    if (hist == 3'b110) begin
                        k++;
                        if (number !== 1'b0 || stuffed !== 1'b1) bad++;
                    end else begin
                        rec = {rec[6:0], number};
                        got++;
                        if (stuffed !== 1'b0) bad++;
                    end
                end else if (number !== 1'b0 || stuffed !== 1'b0) bad++;
                hist = {hist[1:0], number};
                i++;
                @(negedge clk);
            end
            checks++;
            if (pre !== 4'b1101) begin fails++; $display("FAIL rnd_preamble frame %0d got %b want 1101", f, pre); end
            checks++;
            if (rec !== d) begin fails++; $display("FAIL rnd_payload frame %0d got %h want %h", f, rec, d); end
            checks++;
            if (bad !== 0) begin fails++; $display("FAIL rnd_stuff_flags frame %0d got %0d bad want 0", f, bad); end
            checks++;
            if (cyc - a !== W + k + 7) begin fails++; $display("FAIL rnd_period frame %0d got %0d want %0d", f, cyc - a, W + k + 7); end
            checks++;
            if (smile_cnt - s0 !== 1 || last_smile !== a + 4) begin
                fails++;
                $display("FAIL rnd_smile frame %0d data %h got %0d at %0d want 1 at %0d", f, d, smile_cnt - s0, last_smile, a + 4);
            end
        end
    endtask

    initial begin
        test_reset;
        test_stuffing;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end
endmodule
